// File: rtl/config_loader_pkg.sv
// config_loader_pkg: shared state encoding and width helpers for the config SRAM loader.
package config_loader_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  function automatic int loader_width(input int addr_bits, input int data_bits);
    return addr_bits + data_bits;
  endfunction
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/config_piso.sv
// config_piso: W-bit parallel-load shift register, shifts left with i_sin entering at bit 0.
module config_piso #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic         i_sin,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_par
);
  logic [W-1:0] r_sreg;
  always_ff @(posedge i_clk)
    if (i_rst) r_sreg <= '0;
    else if (i_load) r_sreg <= i_d;
    else if (i_shift) r_sreg <= {r_sreg[W-2:0], i_sin};
  assign o_par = r_sreg;
endmodule

// File: rtl/config_sram_loader.sv
// config_sram_loader: serializes {data, addr} MSB-first into a config SRAM chain, then strobes config_set.
// CONFIG_LOADER_READBACK_EN adds shift_out capture and rb_valid/rb_addr/rb_data readback ports.
module config_sram_loader
  import config_loader_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 cclk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_BITS-1:0] in_addr,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 shift_enable,
  output logic                 shift_in,
  output logic                 config_set,
`ifdef CONFIG_LOADER_READBACK_EN
  input  logic                 shift_out,
  output logic                 rb_valid,
  output logic [ADDR_BITS-1:0] rb_addr,
  output logic [DATA_BITS-1:0] rb_data,
`endif
  output logic                 busy
);
  localparam int N = loader_width(ADDR_BITS, DATA_BITS);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_shift_enable;
  logic            r_config_set;
  logic            w_accept;
  logic [N-1:0]    w_sreg;
  logic            w_unused;
  assign in_ready = (r_state == IDLE) & ~rst;
  assign w_accept = in_valid & in_ready;
  always_ff @(posedge cclk)
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_shift_enable <= 1'b0;
      r_config_set   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_state        <= SHIFT;
          r_cnt          <= '0;
          r_shift_enable <= 1'b1;
        end
        SHIFT: begin
          r_cnt <= (r_cnt == LAST) ? r_cnt : r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state        <= COMMIT;
            r_shift_enable <= 1'b0;
            r_config_set   <= 1'b1;
          end
        end
        COMMIT: begin
          r_state      <= IDLE;
          r_config_set <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  // Zeros fill in behind the word, so shift_in rests at 0 outside SHIFT.
  config_piso #(.W(N)) u_load (
    .i_clk  (cclk),
    .i_rst  (rst),
    .i_load (w_accept),
    .i_shift(r_shift_enable),
    .i_sin  (1'b0),
    .i_d    ({in_data, in_addr}),
    .o_par  (w_sreg)
  );
  assign w_unused     = ^w_sreg[N-2:0];
  assign shift_in     = w_sreg[N-1];
  assign shift_enable = r_shift_enable;
  assign config_set   = r_config_set;
  assign busy         = r_state != IDLE;
`ifdef CONFIG_LOADER_READBACK_EN
  logic [N-1:0] w_rb;
  // shift_out is sampled on the same edge the chain shifts, so it captures the old contents.
  config_piso #(.W(N)) u_rb (
    .i_clk  (cclk),
    .i_rst  (rst),
    .i_load (1'b0),
    .i_shift(r_shift_enable),
    .i_sin  (shift_out),
    .i_d    ('0),
    .o_par  (w_rb)
  );
  assign rb_valid           = r_config_set;
  assign {rb_data, rb_addr} = w_rb;
`endif
endmodule

// File: tb/tb_config_sram_loader.sv
// tb_config_sram_loader: randomized and directed checks of config_sram_loader against a cycle-timeline model.
module tb_config_sram_loader;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int N  = AB + DB;
  localparam int DEPTH = 8192;
  logic cclk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b1;
  logic in_ready;
  logic [AB-1:0] in_addr = '0;
  logic [DB-1:0] in_data = '0;
  logic shift_enable, shift_in, config_set, busy;
`ifdef CONFIG_LOADER_READBACK_EN
  logic shift_out, rb_valid;
  logic [AB-1:0] rb_addr;
  logic [DB-1:0] rb_data;
`endif
  config_sram_loader #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .cclk(cclk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .shift_enable(shift_enable),
    .shift_in(shift_in), .config_set(config_set),
`ifdef CONFIG_LOADER_READBACK_EN
    .shift_out(shift_out), .rb_valid(rb_valid), .rb_addr(rb_addr), .rb_data(rb_data),
`endif
    .busy(busy)
  );
  always #5 cclk = ~cclk;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  // Timeline model: an acceptance at the end of cycle c books cycles c+1..c+N+1.
  bit m_busy [DEPTH];
  bit m_se   [DEPTH];
  bit m_si   [DEPTH];
  bit m_cs   [DEPTH];
  logic [N-1:0] m_word [DEPTH];
  logic [N-1:0] m_rb   [DEPTH];
  logic [N-1:0] chain = '0;
  logic [N-1:0] last_chain = '0;
  logic [N-1:0] stream = '0;
  int acc_q[$];
  int cs_q[$];
`ifdef CONFIG_LOADER_READBACK_EN
  assign shift_out = chain[N-1];
`endif
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(posedge cclk) begin
    logic [N-1:0] p;
    if (rst) begin
      for (int k = cyc + 1; k < cyc + N + 3 && k < DEPTH; k++) begin
        m_busy[k] = 0; m_se[k] = 0; m_si[k] = 0; m_cs[k] = 0;
      end
    end else if (in_valid && !m_busy[cyc] && cyc + N + 1 < DEPTH) begin
      p = {in_data, in_addr};
      for (int k = 1; k <= N; k++) begin
        m_busy[cyc+k] = 1; m_se[cyc+k] = 1; m_si[cyc+k] = p[N-k];
      end
      m_busy[cyc+N+1] = 1;
      m_cs[cyc+N+1]   = 1;
      m_word[cyc+N+1] = p;
      m_rb[cyc+N+1]   = chain;
      acc_q.push_back(cyc);
    end
    if (shift_enable) chain = {chain[N-2:0], shift_in};
    cyc++;
  end
  always @(negedge cclk) begin
    if (cyc >= 1) begin
      chk("in_ready", in_ready, !m_busy[cyc] && !rst);
      chk("busy", busy, m_busy[cyc]);
      chk("shift_enable", shift_enable, m_se[cyc]);
      chk("shift_in", shift_in, m_si[cyc]);
      chk("config_set", config_set, m_cs[cyc]);
      chk("no_overlap", shift_enable & config_set, 0);
      if (config_set) begin
        chk("chain_word", chain, m_word[cyc]);
        cs_q.push_back(cyc);
        last_chain = chain;
      end
`ifdef CONFIG_LOADER_READBACK_EN
      chk("rb_valid", rb_valid, m_cs[cyc]);
      if (rb_valid) chk("rb_word", {rb_data, rb_addr}, m_rb[cyc]);
`endif
      if (shift_enable) stream = {stream[N-2:0], shift_in};
    end
  end
  task automatic wait_ready();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge cclk);
      if (in_ready) break;
    end
    chk("ready_timeout", i < 100, 1);
  endtask
  task automatic send(input logic [AB-1:0] a, input logic [DB-1:0] d);
    @(posedge cclk); #2;
    in_valid = 1'b1; in_addr = a; in_data = d;
    wait_ready();
    @(posedge cclk); #2;
    in_valid = 1'b0;
  endtask
  task automatic wait_cs(input int target);
    for (int i = 0; i < 60 && cs_q.size() < target; i++) @(negedge cclk);
    chk("commit_seen", cs_q.size() >= target, 1);
  endtask
  initial begin
    int a0, c0;
    repeat (4) @(posedge cclk);
    @(negedge cclk);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_se", shift_enable, 0);
    chk("rst_cs", config_set, 0);
    chk("rst_no_accept", acc_q.size(), 0);
    @(posedge cclk); #2;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge cclk);
    chk("ready_after_rst", in_ready, 1);
    send(8'hA5, 8'h3C);
    wait_cs(1);
    chk("stream_a5_3c", stream, 16'h3CA5);
    chk("cs_latency", cs_q[$] - acc_q[$], 17);
    chk("write_address", last_chain[AB-1:0], 8'hA5);
    chk("write_data", last_chain[N-1:AB], 8'h3C);
    @(posedge cclk); #2;
    in_valid = 1'b1; in_addr = 8'h01; in_data = 8'hFF;
    wait_ready();
    @(posedge cclk); #2;
    in_addr = 8'h80; in_data = 8'h00;
    wait_ready();
    @(posedge cclk); #2;
    in_valid = 1'b0;
    wait_cs(3);
    chk("b2b_accept_gap", acc_q[$] - acc_q[$-1], 18);
    chk("b2b_cs1", cs_q[$-1] - acc_q[$-1], 17);
    chk("b2b_cs2", cs_q[$] - acc_q[$-1], 35);
    chk("b2b_word2", last_chain, 16'h0080);
    a0 = acc_q.size();
    send(8'h5A, 8'hC3);
    in_data = 8'h77;
    for (int i = 0; i < 16; i++) begin
      @(posedge cclk); #2;
      in_valid = ~in_valid;
    end
    in_valid = 1'b0;
    wait_cs(4);
    chk("toggle_accepts", acc_q.size(), a0 + 1);
    chk("toggle_data", last_chain[N-1:AB], 8'hC3);
    chk("toggle_addr", last_chain[AB-1:0], 8'h5A);
    c0 = cs_q.size();
    send(8'h33, 8'hCC);
    repeat (4) @(posedge cclk);
    #2 rst = 1'b1;
    @(posedge cclk); #2;
    rst = 1'b0;
    @(negedge cclk);
    chk("abort_se", shift_enable, 0);
    chk("abort_ready", in_ready, 1);
    repeat (25) @(posedge cclk);
    chk("abort_no_cs", cs_q.size(), c0);
    for (int i = 0; i < 1500; i++) begin
      @(posedge cclk); #2;
      rst      = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_addr  = AB'($urandom);
      in_data  = DB'($urandom);
    end
    @(posedge cclk); #2;
    rst = 1'b0; in_valid = 1'b0;
    repeat (N + 4) @(posedge cclk);
    @(negedge cclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
